if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 im_addr  output  16  fetch address presented to instruction memory.
REQ-006 im_rd_en  output  1  fetch request; instruction memory returns im_instr exactly one cycle later.
REQ-007 im_instr  input  16  instruction word for the request issued in the previous cycle.
REQ-008 redirect  input  1  jump/branch taken; flush and refetch.
REQ-009 redirect_addr  input  16  new fetch address, sampled when redirect=1.
REQ-010 hlt  input  1  level; inhibits new fetch requests.
REQ-011 id_valid  output  1  head entry valid toward decode.
REQ-012 id_ready  input  1  decode accepts head entry.
REQ-013 id_instr  output  16  head instruction.
REQ-014 id_pc  output  16  address of head instruction.
REQ-015 count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-016 Internal state: fetch_pc (16b), inflight bit, circular buffer of DEPTH {instr,pc} entries, read/write pointers, count.
REQ-017 issue = !rst && !redirect && !hlt && (count + inflight) < DEPTH; im_rd_en = issue; im_addr = fetch_pc whenever issue=1 (don't-care otherwise).
REQ-018 On issue: fetch_pc <= fetch_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000); inflight <= 1; issued address recorded as pending pc.
REQ-019 No issue and no redirect: fetch_pc holds; inflight <= 0.
REQ-020 Response: in the cycle after issue (inflight=1, redirect=0), {im_instr, pending pc} written at write pointer; count increments unless a pop occurs the same cycle.
REQ-021 Credit rule in REQ-017 guarantees a response never finds the queue full; push into full queue is a design error (bench assertion).
REQ-022 Pop: id_valid = (count != 0); pop when id_valid && id_ready; read pointer advances, wraps DEPTH-1 -> 0.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-024 id_instr/id_pc reflect the head entry combinationally; hold stable while id_valid=1 and id_ready=0.
REQ-025 No bypass: an instruction is visible on id_valid no earlier than the cycle after its response cycle.
REQ-026 Redirect (highest priority): queue flushed (count <= 0, pointers <= 0), inflight <= 0, response arriving that cycle dropped, any pop that cycle ignored, fetch_pc <= redirect_addr, im_rd_en = 0.
REQ-027 Redirect latency: redirect in cycle N -> im_rd_en with im_addr=redirect_addr in N+1 -> id_valid with id_pc=redirect_addr in N+3 (if hlt=0).
REQ-028 hlt=1: no new issues; a response already in flight is still captured; queue continues to drain to decode; deasserting hlt resumes fetch at the held fetch_pc.
REQ-029 redirect and hlt together: redirect takes effect (flush, load fetch_pc); fetching stays inhibited until hlt=0.
REQ-030 Steady state with id_ready=1, hlt=0: one instruction per cycle, consecutive id_pc values.

Reset
REQ-031 rst=1 forces immediately, independent of clk: fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, all entries 0.
REQ-032 During reset outputs read: im_rd_en=0, id_valid=0, id_instr=16'h0000, id_pc=16'h0000, count=0.
REQ-033 Reset asserted mid-operation discards all queued and in-flight instructions; first cycle after deassertion issues RESET_PC; id_valid rises two cycles later.

Verification
REQ-034 Reset release, id_ready=1, IM returns addr^16'hA5A5 -> im_addr 0,1,2,... one per cycle; id_valid from cycle 2; id_pc 0,1,2 with id_instr 16'hA5A5,16'hA5A4,16'hA5A7.
REQ-035 id_ready=0 for 10 cycles -> exactly 4 requests issued (addr 0..3), count=4, im_rd_en=0 after; id_ready=1 -> id_pc 0,1,2,3 in order, fetch resumes at 4.
REQ-036 Queue holds 3 entries, one in flight, redirect=1 with redirect_addr=16'h0040 -> count=0 next cycle, in-flight word never appears, next im_addr=16'h0040, id_pc=16'h0040 three cycles after redirect.
REQ-037 redirect_addr=16'hFFFE, id_ready=1 -> id_pc sequence FFFE, FFFF, 0000, 0001.
REQ-038 hlt=1 with one request in flight and 2 entries queued -> no further im_rd_en, 3 instructions delivered, count=0; hlt=0 -> fetch resumes at next sequential address.
REQ-039 rst pulsed mid-stream between clock edges with count=3 -> count, id_valid, im_rd_en go 0 without a clock edge; restart at RESET_PC per REQ-033.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction fetch front end. It issues sequential fetches to a one-cycle
// latency instruction memory and buffers the returned words in a small
// circular queue that feeds decode. A fetch is issued only when the queue
// still has room for it, so every response is guaranteed a free slot.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   im_addr        fetch address to instruction memory (valid while im_rd_en)
//   im_rd_en       fetch request; data returns on im_instr one cycle later
//   im_instr       instruction word for the previous cycle's request
//   redirect       taken jump/branch: flush queue and refetch
//   redirect_addr  new fetch address, sampled while redirect=1
//   hlt            level; inhibits new fetch requests
//   id_valid       head entry valid toward decode
//   id_ready       decode accepts head entry
//   id_instr       head instruction word
//   id_pc          address of head instruction
//   count          number of occupied queue entries
// ---------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [15:0]            im_addr,
   output logic                   im_rd_en,
   input  logic [15:0]            im_instr,
   input  logic                   redirect,
   input  logic [15:0]            redirect_addr,
   input  logic                   hlt,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [15:0]            id_instr,
   output logic [15:0]            id_pc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned CRW = CW + 1;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   logic [15:0]   fetch_pc;
   logic          inflight;
   logic [15:0]   pending_pc;
   entry_t        fifo [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;

   logic [CRW-1:0] credit_used;
   logic           issue;
   logic           push;
   logic           pop;

   // Occupied slots plus the one reserved by an outstanding request.
   assign credit_used = {1'b0, count_q} + CRW'(inflight);

   assign issue = !rst && !redirect && !hlt && (credit_used < CRW'(DEPTH));
   assign push  = inflight && !redirect;
   assign pop   = id_valid && id_ready && !redirect;

   assign im_rd_en = issue;
   assign im_addr  = fetch_pc;

   assign id_valid = (count_q != '0);
   assign id_instr = fifo[rd_ptr].instr;
   assign id_pc    = fifo[rd_ptr].pc;
   assign count    = count_q;

   // Fetch PC, in-flight tracking, queue storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         inflight   <= 1'b0;
         pending_pc <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo[i] <= '0;
         end
      end else if (redirect) begin
         // Flush wins over any response or pop in the same cycle.
         fetch_pc <= redirect_addr;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
      end else begin
         if (issue) begin
            fetch_pc   <= fetch_pc + 16'd1;
            inflight   <= 1'b1;
            pending_pc <= fetch_pc;
         end else begin
            inflight <= 1'b0;
         end

         if (push) begin
            fifo[wr_ptr] <= '{instr: im_instr, pc: pending_pc};
            wr_ptr       <= wr_ptr + PW'(1);
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Self-checking bench for if_fetch_queue. The instruction memory returns
// addr ^ 16'hA5A5 one cycle after a request. A transaction-level model
// (fetch pc, one pending request, a queue of {instr,pc}) predicts the
// outputs each cycle; directed scenarios add fixed expected sequences.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] SALT     = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_instr = 16'h0000;
   logic        redirect = 1'b0;
   logic [15:0] redirect_addr = 16'h0000;
   logic        hlt = 1'b0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .im_addr      (im_addr),
      .im_rd_en     (im_rd_en),
      .im_instr     (im_instr),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .hlt          (hlt),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Instruction memory: one-cycle read latency, junk when not requested.
   always @(posedge clk) im_instr <= im_rd_en ? (im_addr ^ SALT) : 16'hDEAD;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_pend;
   bit          m_inflight;
   logic [31:0] m_q[$];

   bit          e_issue;
   bit          e_valid;
   logic [15:0] e_pc;
   logic [15:0] e_instr;
   int          e_count;

   task automatic model_reset();
      m_pc       = RESET_PC;
      m_pend     = 16'h0000;
      m_inflight = 1'b0;
      m_q.delete();
   endtask

   task automatic model_eval();
      e_count = m_q.size();
      e_valid = !rst && (e_count != 0);
      e_issue = !rst && !redirect && !hlt && ((e_count + int'(m_inflight)) < DEPTH);
      e_pc    = 16'h0000;
      e_instr = 16'h0000;
      if (e_valid) {e_instr, e_pc} = m_q[0];
   endtask

   task automatic model_advance();
      if (redirect) begin
         m_q.delete();
         m_inflight = 1'b0;
         m_pc       = redirect_addr;
      end else begin
         if (e_valid && id_ready) void'(m_q.pop_front());
         if (m_inflight) m_q.push_back({m_pend ^ SALT, m_pend});
         if (e_issue) begin
            m_pend     = m_pc;
            m_pc       = m_pc + 16'd1;
            m_inflight = 1'b1;
         end else begin
            m_inflight = 1'b0;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic step();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      redirect = 1'b0;
      hlt      = 1'b0;
      id_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_checks++; if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b exp 0", im_rd_en); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", id_valid); end
      n_checks++; if (id_instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", id_instr); end
      n_checks++; if (id_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", id_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
   endtask

   task automatic test_stream();
      apply_reset();
      id_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         settle();
         n_checks++;
         if (im_rd_en !== 1'b1 || im_addr !== 16'(c)) begin
            n_fail++; $display("FAIL stream_issue cyc %0d got en=%b addr=%h exp en=1 addr=%h", c, im_rd_en, im_addr, 16'(c));
         end
         n_checks++;
         if (id_valid !== (c >= 2)) begin
            n_fail++; $display("FAIL stream_valid cyc %0d got %b exp %b", c, id_valid, (c >= 2));
         end
         if (c >= 2) begin
            n_checks++;
            if (id_pc !== 16'(c - 2) || id_instr !== (16'(c - 2) ^ SALT)) begin
               n_fail++; $display("FAIL stream_head cyc %0d got pc=%h instr=%h exp pc=%h instr=%h", c, id_pc, id_instr, 16'(c - 2), 16'(c - 2) ^ SALT);
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      int n_iss = 0;
      int first_addr = -1;
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         settle();
         if (im_rd_en) begin
            n_checks++;
            if (im_addr !== 16'(n_iss)) begin
               n_fail++; $display("FAIL bp_addr got %h exp %h", im_addr, 16'(n_iss));
            end
            n_iss++;
         end
         step();
      end
      settle();
      n_checks++; if (n_iss != DEPTH) begin n_fail++; $display("FAIL bp_issues got %0d exp %0d", n_iss, DEPTH); end
      n_checks++; if (count !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", count, DEPTH); end
      n_checks++; if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall got %b exp 0", im_rd_en); end
      id_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         settle();
         if (k < 4) begin
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 16'(k)) begin
               n_fail++; $display("FAIL bp_drain k %0d got v=%b pc=%h exp v=1 pc=%h", k, id_valid, id_pc, 16'(k));
            end
         end
         if (im_rd_en && first_addr < 0) first_addr = int'(im_addr);
         step();
      end
      n_checks++; if (first_addr != 4) begin n_fail++; $display("FAIL bp_resume got %0d exp 4", first_addr); end
   endtask

   task automatic test_redirect();
      apply_reset();
      for (int c = 0; c < 4; c++) begin settle(); step(); end
      settle();
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rd_pre_count got %0d exp 3", count); end
      redirect      = 1'b1;
      redirect_addr = 16'h0040;
      settle();
      n_checks++; if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL rd_no_issue got %b exp 0", im_rd_en); end
      step();
      redirect = 1'b0;
      id_ready = 1'b1;
      settle();
      n_checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got count=%0d v=%b exp 0 0", count, id_valid); end
      n_checks++; if (im_rd_en !== 1'b1 || im_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_refetch got en=%b addr=%h exp 1 0040", im_rd_en, im_addr); end
      step();
      settle();
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_no_bypass got %b exp 0", id_valid); end
      step();
      settle();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 16'h0040 || id_instr !== (16'h0040 ^ SALT)) begin
         n_fail++; $display("FAIL rd_target got v=%b pc=%h instr=%h exp 1 0040 %h", id_valid, id_pc, id_instr, 16'h0040 ^ SALT);
      end
      step();
   endtask

   task automatic test_wrap();
      logic [15:0] got[4];
      int n = 0;
      redirect      = 1'b1;
      redirect_addr = 16'hFFFE;
      id_ready      = 1'b1;
      hlt           = 1'b0;
      settle();
      step();
      redirect = 1'b0;
      for (int c = 0; c < 8; c++) begin
         settle();
         if (id_valid && n < 4) begin got[n] = id_pc; n++; end
         step();
      end
      n_checks++; if (n != 4) begin n_fail++; $display("FAIL wrap_len got %0d exp 4", n); end
      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (got[k] !== 16'hFFFE + 16'(k)) begin
            n_fail++; $display("FAIL wrap_pc k %0d got %h exp %h", k, got[k], 16'hFFFE + 16'(k));
         end
      end
   endtask

   task automatic test_halt();
      int n_iss = 0;
      int delivered = 0;
      apply_reset();
      for (int c = 0; c < 3; c++) begin settle(); step(); end
      settle();
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL hlt_pre_count got %0d exp 2", count); end
      hlt      = 1'b1;
      id_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         settle();
         if (im_rd_en) n_iss++;
         if (id_valid) begin
            n_checks++;
            if (id_pc !== 16'(delivered)) begin n_fail++; $display("FAIL hlt_order got %h exp %h", id_pc, 16'(delivered)); end
            delivered++;
         end
         step();
      end
      settle();
      n_checks++; if (n_iss != 0) begin n_fail++; $display("FAIL hlt_issues got %0d exp 0", n_iss); end
      n_checks++; if (delivered != 3) begin n_fail++; $display("FAIL hlt_delivered got %0d exp 3", delivered); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL hlt_count got %0d exp 0", count); end
      hlt = 1'b0;
      settle();
      n_checks++; if (im_rd_en !== 1'b1 || im_addr !== 16'h0003) begin n_fail++; $display("FAIL hlt_resume got en=%b addr=%h exp 1 0003", im_rd_en, im_addr); end
      step();
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int c = 0; c < 4; c++) begin settle(); step(); end
      settle();
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mrst_pre_count got %0d exp 3", count); end
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mrst_count got %0d exp 0", count); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got %b exp 0", id_valid); end
      n_checks++; if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL mrst_rd_en got %b exp 0", im_rd_en); end
      n_checks++; if (id_instr !== 16'h0000 || id_pc !== 16'h0000) begin n_fail++; $display("FAIL mrst_head got instr=%h pc=%h exp 0000 0000", id_instr, id_pc); end
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      id_ready = 1'b1;
      settle();
      n_checks++; if (im_rd_en !== 1'b1 || im_addr !== RESET_PC) begin n_fail++; $display("FAIL mrst_restart got en=%b addr=%h exp 1 %h", im_rd_en, im_addr, RESET_PC); end
      step();
      settle();
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_early got %b exp 0", id_valid); end
      step();
      settle();
      n_checks++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin n_fail++; $display("FAIL mrst_first got v=%b pc=%h exp 1 %h", id_valid, id_pc, RESET_PC); end
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         redirect = ($urandom_range(15) == 0);
         redirect_addr = ($urandom_range(3) == 0) ? (16'hFFFC + 16'($urandom_range(3))) : 16'($urandom);
         hlt      = ($urandom_range(3) == 0);
         id_ready = ($urandom_range(3) != 0);
         settle();
         n_checks++;
         if (im_rd_en !== e_issue) begin n_fail++; $display("FAIL rnd_rd_en cyc %0d got %b exp %b", c, im_rd_en, e_issue); end
         if (e_issue) begin
            n_checks++;
            if (im_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, im_addr, m_pc); end
         end
         n_checks++;
         if (id_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, id_valid, e_valid); end
         if (e_valid) begin
            n_checks++;
            if (id_pc !== e_pc || id_instr !== e_instr) begin
               n_fail++; $display("FAIL rnd_head cyc %0d got pc=%h instr=%h exp pc=%h instr=%h", c, id_pc, id_instr, e_pc, e_instr);
            end
         end
         n_checks++;
         if (int'(count) != e_count) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, e_count); end
         step();
      end
      redirect = 1'b0;
      hlt      = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_mid_reset();
      apply_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
